// File: rtl/nms_frame_sequencer.sv
// Streaming 3x3 non-maximum suppression over one raster frame of {mag,dir} pixels.
// Two line buffers plus a 3x3 window feed a single registered output stage.
module nms_frame_sequencer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_mag,
  input  logic [1:0]        in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       out_mag,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds data stable while valid is high and ready is low.

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   in_c, oc_c;
  logic [RW-1:0]   in_r, oc_r;
  logic [NW-1:0]   cons_cnt;
  logic            prod_all;

  logic            accept, consume, produce, last_consume;
  logic            in_last_col, in_last_row, oc_last_col, oc_last_row;
  logic            border, keep;
  logic signed [10:0] c_mag, n1_mag, n2_mag;
  logic [10:0]     result;

  // Line buffers: lb1 holds the previous row (with dir), lb0 the row before it.
  logic [12:0]     lb1 [IMG_W];
  logic [10:0]     lb0 [IMG_W];
  logic [10:0]     t_l, t_m, m_l, b_l, b_m;
  logic [12:0]     m_m;
  logic [10:0]     t_r, m_r_mag, b_r;

  assign accept       = in_valid && in_ready;
  assign consume      = out_valid && out_ready;
  assign in_last_col  = (in_c == CW'(IMG_W - 1));
  assign in_last_row  = (in_r == RW'(IMG_H - 1));
  assign oc_last_col  = (oc_c == CW'(IMG_W - 1));
  assign oc_last_row  = (oc_r == RW'(IMG_H - 1));
  assign last_consume = consume && (cons_cnt == NW'(NPIX - 1));

  assign in_ready   = ((state == S_FILL) || (state == S_RUN)) && (!out_valid || out_ready);
  assign produce    = ((state == S_RUN) && accept) ||
                      ((state == S_FLUSH) && !prod_all && (!out_valid || out_ready));
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_FLUSH) && last_consume;
  assign state_dbg  = state;

  // Incoming column of the window while input (r+1,c+1) is being accepted.
  assign t_r     = lb0[in_c];
  assign m_r_mag = lb1[in_c][12:2];
  assign b_r     = in_mag;

  always_comb begin
    c_mag  = $signed(m_m[12:2]);
    n1_mag = $signed(m_l);
    n2_mag = $signed(m_r_mag);
    case (m_m[1:0])
      2'b00: begin n1_mag = $signed(m_l); n2_mag = $signed(m_r_mag); end
      2'b01: begin n1_mag = $signed(t_m); n2_mag = $signed(b_m);     end
      2'b10: begin n1_mag = $signed(t_r); n2_mag = $signed(b_l);     end
      default: begin n1_mag = $signed(t_l); n2_mag = $signed(b_r);   end
    endcase
  end

  assign keep   = (c_mag >= n1_mag) && (c_mag >= n2_mag);
  assign border = (oc_r == '0) || oc_last_row || (oc_c == '0) || oc_last_col;
  assign result = (border || !keep) ? 11'd0 : m_m[12:2];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FILL;
      S_FILL:  if (accept && (in_r == RW'(1)) && (in_c == '0)) state_nx = S_RUN;
      S_RUN:   if (accept && in_last_col && in_last_row) state_nx = S_FLUSH;
      S_FLUSH: if (last_consume) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_c      <= '0;
      in_r      <= '0;
      oc_c      <= '0;
      oc_r      <= '0;
      cons_cnt  <= '0;
      prod_all  <= 1'b0;
      out_valid <= 1'b0;
      out_mag   <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && start) begin
        in_c     <= '0;
        in_r     <= '0;
        oc_c     <= '0;
        oc_r     <= '0;
        cons_cnt <= '0;
        prod_all <= 1'b0;
      end else begin
        if (accept) begin
          in_c <= in_last_col ? '0 : in_c + 1'b1;
          if (in_last_col) in_r <= in_last_row ? '0 : in_r + 1'b1;
        end
        if (produce) begin
          oc_c <= oc_last_col ? '0 : oc_c + 1'b1;
          if (oc_last_col) oc_r <= oc_last_row ? '0 : oc_r + 1'b1;
          if (oc_last_col && oc_last_row) prod_all <= 1'b1;
        end
        if (consume) cons_cnt <= last_consume ? '0 : cons_cnt + 1'b1;
      end
      // A new result overrides a same-cycle consume so out_valid stays high.
      if (produce) begin
        out_valid <= 1'b1;
        out_mag   <= result;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Data path carries no reset: stale contents only ever reach border outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[in_c] <= lb1[in_c][12:2];
      lb1[in_c] <= {in_mag, in_dir};
      t_l <= t_m;
      t_m <= t_r;
      m_l <= m_m[12:2];
      m_m <= lb1[in_c];
      b_l <= b_m;
      b_m <= b_r;
    end
  end

endmodule

// File: tb/tb_nms_frame_sequencer.sv
// Directed vector bench for nms_frame_sequencer at IMG_W=4, IMG_H=3.
// Frames come from a table of pixel/expected-output records; resets are hand sequences.
module tb_nms_frame_sequencer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk, rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic        busy, frame_done;
  logic [10:0] in_mag, out_mag;
  logic [1:0]  in_dir, state_dbg;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    string               name;
    logic [N-1:0][10:0]  mag;
    logic [N-1:0][1:0]   dir;
    logic [N-1:0][10:0]  exp;
    int                  stall_at;
    int                  stall_len;
    bit                  in_gap;
    bit                  start_mid;
  } vec_t;

  vec_t vecs[8];

  nms_frame_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
    .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_vecs();
    for (int v = 0; v < 8; v++) begin
      vecs[v].mag = '0; vecs[v].dir = '0; vecs[v].exp = '0;
      vecs[v].stall_at = 0; vecs[v].stall_len = 0;
      vecs[v].in_gap = 1'b0; vecs[v].start_mid = 1'b0;
    end
    vecs[0].name = "all5";
    for (int i = 0; i < N; i++) vecs[0].mag[i] = 11'd5;
    vecs[0].exp[5] = 11'd5; vecs[0].exp[6] = 11'd5;
    vecs[1] = vecs[0];
    vecs[1].name = "all5_stall"; vecs[1].stall_at = 8; vecs[1].stall_len = 5;
    vecs[2].name = "row1_peak";
    vecs[2].mag[4] = 11'd3; vecs[2].mag[5] = 11'd9; vecs[2].mag[6] = 11'd4; vecs[2].mag[7] = 11'd2;
    vecs[2].exp[5] = 11'd9;
    vecs[3].name = "col_dir01";
    vecs[3].mag[1] = 11'd1; vecs[3].mag[5] = 11'd6; vecs[3].mag[9] = 11'd7;
    vecs[3].dir[5] = 2'b01; vecs[3].in_gap = 1'b1;
    vecs[4].name = "row1_dir00";
    vecs[4].mag[1] = 11'd1; vecs[4].mag[9] = 11'd7;
    vecs[4].mag[4] = 11'd2; vecs[4].mag[5] = 11'd6; vecs[4].mag[6] = 11'd1; vecs[4].mag[7] = 11'd3;
    vecs[4].exp[5] = 11'd6;
    vecs[5].name = "diag";
    vecs[5].mag[1] = 11'd5; vecs[5].mag[2] = 11'd9;
    vecs[5].mag[5] = 11'd8; vecs[5].dir[5] = 2'b10;
    vecs[5].mag[6] = 11'd5; vecs[5].dir[6] = 2'b11;
    vecs[5].mag[8] = 11'd1; vecs[5].mag[11] = 11'(-2);
    vecs[5].exp[6] = 11'd5; vecs[5].start_mid = 1'b1;
    vecs[6].name = "negative";
    for (int i = 0; i < W; i++) vecs[6].mag[i] = 11'd100;
    vecs[6].mag[4] = 11'(-10); vecs[6].mag[5] = 11'(-7); vecs[6].mag[6] = 11'(-5); vecs[6].mag[7] = 11'(-6);
    vecs[6].exp[6] = 11'(-5); vecs[6].stall_at = 12; vecs[6].stall_len = 3;
    vecs[7].name = "signed_cmp";
    vecs[7].mag[4] = 11'(-1); vecs[7].mag[5] = 11'd1; vecs[7].mag[6] = 11'(-2); vecs[7].mag[7] = 11'(-4);
    for (int i = 8; i < N; i++) vecs[7].mag[i] = 11'd50;
    vecs[7].exp[5] = 11'd1;
  endtask

  // Driver + scoreboard for one full frame
  task automatic run_frame(input vec_t v);
    int pix, nout, nfd;
    bit prev_stall, hs;
    logic [10:0] last_mag;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(v.exp[i]);
    pix = 0; nout = 0; nfd = 0; prev_stall = 1'b0; last_mag = '0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk({v.name, " idle_busy"}, busy, 0);
    @(negedge clk);
    #1 chk({v.name, " start_busy"}, busy, 1);
    for (int cyc = 0; cyc < 200 && nout < N; cyc++) begin
      out_ready = !((v.stall_len != 0) && (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len));
      in_valid  = (pix < N) && !(v.in_gap && (cyc % 3 == 2));
      in_mag    = v.mag[(pix < N) ? pix : 0];
      in_dir    = v.dir[(pix < N) ? pix : 0];
      start     = v.start_mid && (cyc == 5);
      #1;
      if (prev_stall) begin
        chk({v.name, " stall_valid"}, out_valid, 1);
        chk({v.name, " stall_mag"}, out_mag, last_mag);
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) chk({v.name, " stall_in_ready"}, in_ready, 0);
      last_mag = out_mag;
      if (in_valid && in_ready) pix++;
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_output: got %0h expected none", v.name, out_mag);
        end else begin
          chk($sformatf("%s out[%0d]", v.name, nout), out_mag, exp_q.pop_front());
        end
        nout++;
      end
      chk($sformatf("%s frame_done c%0d", v.name, cyc), frame_done, hs && (nout == N));
      if (frame_done) nfd++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk({v.name, " out_count"}, nout, N);
    chk({v.name, " in_count"}, pix, N);
    chk({v.name, " done_count"}, nfd, 1);
    #1;
    chk({v.name, " end_busy"}, busy, 0);
    chk({v.name, " end_valid"}, out_valid, 0);
  endtask

  // Start a frame, accept n_in pixels, then reset asynchronously mid-cycle
  task automatic abort_frame(input int n_in);
    int acc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_mag = 11'd5; in_dir = 2'b00; out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 50 && acc < n_in; k++) begin
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk($sformatf("abort%0d accepted", n_in), acc, n_in);
    #1 chk($sformatf("abort%0d pre_valid", n_in), out_valid, 1);
    chk($sformatf("abort%0d pre_busy", n_in), busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk($sformatf("abort%0d rst_valid", n_in), out_valid, 0);
    chk($sformatf("abort%0d rst_in_ready", n_in), in_ready, 0);
    chk($sformatf("abort%0d rst_busy", n_in), busy, 0);
    chk($sformatf("abort%0d rst_mag", n_in), out_mag, 0);
    chk($sformatf("abort%0d rst_done", n_in), frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mag = '0; in_dir = '0;
    build_vecs();
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset out_mag", out_mag, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle in_ready", in_ready, 0);

    for (int v = 0; v < 8; v++) run_frame(vecs[v]);

    abort_frame(8);
    run_frame(vecs[0]);
    abort_frame(6);
    run_frame(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
